// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter. Each shift level is followed by a register stage,
// with valid/ready flow control and a sideband tag that travels with every operation.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  typedef enum logic [1:0] {
    ModeSrl = 2'b00,
    ModeSra = 2'b01,
    ModeSll = 2'b10,
    ModeRor = 2'b11
  } mode_e;

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("pipelined_barrel_shifter: WIDTH must be a power of two and at least 4");
  end

  logic advance;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int unsigned Amt = 1 << k;

    // src_rem[0] selects this level; higher bits are still owed to later levels.
    logic                 src_valid;
    logic [WIDTH-1:0]     src_data;
    logic [SHAMT_W-1-k:0] src_rem;
    mode_e                src_mode;
    logic [TAG_W-1:0]     src_tag;
    logic [WIDTH-1:0]     shifted;

    logic                 valid_d, valid_q;
    logic [WIDTH-1:0]     data_d, data_q;
    logic [TAG_W-1:0]     tag_d, tag_q;

    if (k == 0) begin : g_src
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign src_rem   = in_shamt;
      assign src_mode  = mode_e'(in_mode);
      assign src_tag   = in_tag;
    end else begin : g_src
      assign src_valid = g_stage[k-1].valid_q;
      assign src_data  = g_stage[k-1].data_q;
      assign src_rem   = g_stage[k-1].g_ctrl.rem_q;
      assign src_mode  = g_stage[k-1].g_ctrl.mode_q;
      assign src_tag   = g_stage[k-1].tag_q;
    end

    always_comb begin
      shifted = src_data;
      if (src_rem[0]) begin
        unique case (src_mode)
          ModeSrl: shifted = src_data >> Amt;
          ModeSra: shifted = $signed(src_data) >>> Amt;
          ModeSll: shifted = src_data << Amt;
          ModeRor: shifted = {src_data[Amt-1:0], src_data[WIDTH-1:Amt]};
        endcase
      end
    end

    // Bubbles advance too, so the output registers always hold defined contents.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      tag_d   = tag_q;
      if (advance) begin
        valid_d = src_valid;
        data_d  = shifted;
        tag_d   = src_tag;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        tag_q   <= tag_d;
      end
    end

    if (k < SHAMT_W - 1) begin : g_ctrl
      logic [SHAMT_W-2-k:0] rem_d, rem_q;
      mode_e                mode_d, mode_q;

      always_comb begin
        rem_d  = rem_q;
        mode_d = mode_q;
        if (advance) begin
          rem_d  = src_rem[SHAMT_W-1-k:1];
          mode_d = src_mode;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_q  <= '0;
          mode_q <= ModeSrl;
        end else begin
          rem_q  <= rem_d;
          mode_q <= mode_d;
        end
      end
    end
  end

  assign out_valid = g_stage[SHAMT_W-1].valid_q;
  assign out_data  = g_stage[SHAMT_W-1].data_q;
  assign out_tag   = g_stage[SHAMT_W-1].tag_q;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

endmodule
